// File: rtl/spi_shift_engine.sv
// SPI shift engine: one-byte full-duplex transfer with fixed CPOL/CPHA and SCLK rate.
// Runs LEAD half-period, 2*DATA_W SCLK edges, TRAIL half-period; chip-select high aborts.
module spi_shift_engine #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned DATA_W  = 8,
  parameter bit          CPOL    = 1'b0,
  parameter bit          CPHA    = 1'b0
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              start_i,
  input  logic [DATA_W-1:0] data_in_bi,
  input  logic              spi_cs_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] data_out_bo,
  input  logic              spi_miso_i,
  output logic              spi_mosi_o,
  output logic              spi_sclk_o
);

  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned EDGE_W = $clog2(2 * DATA_W + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST    = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] LAST_EDGE   = EDGE_W'(2 * DATA_W);
  localparam logic [EDGE_W-1:0] SHIFT_FIRST = EDGE_W'(3);
  localparam logic [EDGE_W-1:0] SHIFT_LAST  = EDGE_W'(2 * DATA_W - 2);

  typedef enum logic [1:0] {ST_IDLE, ST_LEAD, ST_SHIFT, ST_TRAIL} state_e;

  state_e              state_q;
  logic [DIV_W-1:0]    div_q;
  logic [EDGE_W-1:0]   edge_q;
  logic [DATA_W-1:0]   tx_q, rx_q, data_out_q;
  logic                busy_q, done_q, mosi_q, sclk_q;

  logic                tick, edge_now, leading, shift_en, sample_en;
  logic [EDGE_W-1:0]   edge_n;
  logic [DATA_W-1:0]   tx_d, rx_d;

  // Each SCLK edge lands on the HCLK posedge that ends a half-period; edge_n is its 1-based number.
  always_comb begin
    tick     = (div_q == DIV_LAST);
    edge_n   = edge_q + 1'b1;
    edge_now = tick && ((state_q == ST_LEAD) || (state_q == ST_SHIFT));
    leading  = edge_n[0];
    if (CPHA) begin
      shift_en  = edge_now && leading && (edge_n >= SHIFT_FIRST);
      sample_en = edge_now && !leading;
    end else begin
      shift_en  = edge_now && !leading && (edge_n <= SHIFT_LAST);
      sample_en = edge_now && leading;
    end
    tx_d = shift_en  ? {tx_q[DATA_W-2:0], 1'b0}       : tx_q;
    rx_d = sample_en ? {rx_q[DATA_W-2:0], spi_miso_i} : rx_q;
  end

  // Handshake: start_i is taken only while busy_o=0 (a start in the done_o cycle is legal);
  // busy_o then holds until the done_o pulse, or until spi_cs_i=1 aborts without done_o.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= ST_IDLE;
      div_q      <= '0;
      edge_q     <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      data_out_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mosi_q     <= 1'b1;
      sclk_q     <= CPOL;
    end else begin
      done_q <= 1'b0;
      if (state_q == ST_IDLE) begin
        if (start_i) begin
          state_q <= ST_LEAD;
          busy_q  <= 1'b1;
          tx_q    <= data_in_bi;
          rx_q    <= '0;
          mosi_q  <= data_in_bi[DATA_W-1];
          div_q   <= '0;
          edge_q  <= '0;
        end
      end else if (spi_cs_i) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
        mosi_q  <= 1'b1;
        sclk_q  <= CPOL;
        div_q   <= '0;
        edge_q  <= '0;
      end else begin
        div_q  <= tick ? '0 : div_q + 1'b1;
        tx_q   <= tx_d;
        rx_q   <= rx_d;
        mosi_q <= tx_d[DATA_W-1];
        if (edge_now) begin
          sclk_q <= ~sclk_q;
          edge_q <= edge_n;
        end
        case (state_q)
          ST_LEAD:  if (tick) state_q <= ST_SHIFT;
          ST_SHIFT: if (tick && (edge_n == LAST_EDGE)) state_q <= ST_TRAIL;
          ST_TRAIL: begin
            if (tick) begin
              state_q    <= ST_IDLE;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              data_out_q <= rx_q;
              mosi_q     <= 1'b1;
              edge_q     <= '0;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign data_out_bo = data_out_q;
  assign spi_mosi_o  = mosi_q;
  assign spi_sclk_o  = sclk_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Bench for spi_shift_engine: default build (mode 0, CLK_DIV=4) and a mode-3 build with CLK_DIV=1.
// Expected words come from a serial reference model of the SPI wire, not from the DUT.
module tb_spi_shift_engine;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  int n_vec = 0;
  int n_err = 0;

  // default build
  logic       start0 = 1'b0, cs0 = 1'b0, loop0 = 1'b1, pbit0 = 1'b0;
  logic [7:0] din0 = '0, pat0 = '0;
  logic       busy0, done0, mosi0, sclk0;
  logic [7:0] dout0;
  logic       miso0;
  int         pidx0 = 0;
  assign miso0 = loop0 ? mosi0 : pbit0;

  spi_shift_engine u_dut0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .start_i(start0), .data_in_bi(din0), .spi_cs_i(cs0),
    .busy_o(busy0), .done_o(done0), .data_out_bo(dout0), .spi_miso_i(miso0),
    .spi_mosi_o(mosi0), .spi_sclk_o(sclk0)
  );

  // mode-3 build, fastest clock
  logic       start1 = 1'b0, cs1 = 1'b0, pbit1 = 1'b0;
  logic [7:0] din1 = '0, pat1 = '0;
  logic       busy1, done1, mosi1, sclk1;
  logic [7:0] dout1;
  int         pidx1 = 0;

  spi_shift_engine #(.CLK_DIV(1), .DATA_W(8), .CPOL(1'b1), .CPHA(1'b1)) u_dut1 (
    .HCLK(HCLK), .HRESETn(HRESETn), .start_i(start1), .data_in_bi(din1), .spi_cs_i(cs1),
    .busy_o(busy1), .done_o(done1), .data_out_bo(dout1), .spi_miso_i(pbit1),
    .spi_mosi_o(mosi1), .spi_sclk_o(sclk1)
  );

  // Wire-level observers and the MISO slave models
  int   edges0 = 0, edges1 = 0, dones0 = 0, dones1 = 0;
  logic cap0[$];
  logic cap1[$];
  always @(sclk0) edges0++;
  always @(sclk1) edges1++;
  always @(posedge sclk0) cap0.push_back(mosi0);
  always @(posedge sclk1) if (busy1 === 1'b1) cap1.push_back(mosi1);
  always @(posedge HCLK) begin
    if (done0 === 1'b1) dones0++;
    if (done1 === 1'b1) dones1++;
  end
  // mode 0 slave: first bit presented up front, next bit after each trailing (falling) edge
  always @(negedge sclk0) if (!loop0 && busy0 === 1'b1) begin
    pidx0++;
    if (pidx0 < 8) pbit0 = pat0[7-pidx0];
  end
  // mode 3 slave: presents the next bit on each leading (falling) edge
  always @(negedge sclk1) if (busy1 === 1'b1) begin
    if (pidx1 < 8) pbit1 = pat1[7-pidx1];
    pidx1++;
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic start_xfer0(input logic [7:0] d);
    din0 = d;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
  endtask

  task automatic wait_busy0(output int cnt);
    cnt = 0;
    while (busy0 === 1'b1 && cnt < 500) begin
      cnt++;
      tick();
    end
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    tick();
    tick();
    n_vec++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL reset_busy0 got %b exp 0", busy0); end
    n_vec++; if (done0 !== 1'b0) begin n_err++; $display("FAIL reset_done0 got %b exp 0", done0); end
    n_vec++; if (dout0 !== 8'h00) begin n_err++; $display("FAIL reset_dout0 got %h exp 00", dout0); end
    n_vec++; if (sclk0 !== 1'b0) begin n_err++; $display("FAIL reset_sclk0 got %b exp 0", sclk0); end
    n_vec++; if (mosi0 !== 1'b1) begin n_err++; $display("FAIL reset_mosi0 got %b exp 1", mosi0); end
    n_vec++; if (sclk1 !== 1'b1) begin n_err++; $display("FAIL reset_sclk1 got %b exp 1", sclk1); end
    n_vec++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL reset_busy1 got %b exp 0", busy1); end
    HRESETn = 1'b1;
    tick();
  endtask

  task automatic test_loopback_a5();
    int cnt;
    logic [7:0] d;
    d = 8'hA5;
    loop0 = 1'b1; edges0 = 0; dones0 = 0; cap0.delete();
    start_xfer0(d);
    wait_busy0(cnt);
    n_vec++; if (cnt != 68) begin n_err++; $display("FAIL a5_busy_len got %0d exp 68", cnt); end
    n_vec++; if (done0 !== 1'b1) begin n_err++; $display("FAIL a5_done got %b exp 1", done0); end
    n_vec++; if (dout0 !== d) begin n_err++; $display("FAIL a5_dout got %h exp %h", dout0, d); end
    tick();
    n_vec++; if (dones0 != 1) begin n_err++; $display("FAIL a5_done_count got %0d exp 1", dones0); end
    n_vec++; if (edges0 != 16) begin n_err++; $display("FAIL a5_edges got %0d exp 16", edges0); end
    n_vec++; if (cap0.size() != 8) begin n_err++; $display("FAIL a5_mosi_count got %0d exp 8", cap0.size()); end
    for (int i = 0; i < 8 && i < cap0.size(); i++) begin
      n_vec++;
      if (cap0[i] !== ((d >> (7 - i)) & 8'h1) != 0)
        begin n_err++; $display("FAIL a5_mosi_bit%0d got %b exp %b", i, cap0[i], d[7-i]); end
    end
  endtask

  task automatic test_random_data();
    int cnt;
    logic [7:0] d;
    for (int k = 0; k < 6; k++) begin
      d = 8'($urandom_range(0, 255));
      loop0 = (k < 3);
      pat0 = 8'($urandom_range(0, 255));
      pidx0 = 0;
      pbit0 = (pat0 >> 7) != 0;
      start_xfer0(d);
      wait_busy0(cnt);
      n_vec++; if (cnt != 68) begin n_err++; $display("FAIL rand%0d_busy_len got %0d exp 68", k, cnt); end
      n_vec++;
      if (dout0 !== (loop0 ? d : pat0))
        begin n_err++; $display("FAIL rand%0d_dout got %h exp %h", k, dout0, loop0 ? d : pat0); end
      tick();
    end
    loop0 = 1'b1;
  endtask

  task automatic test_mode3();
    int cnt;
    n_vec++; if (sclk1 !== 1'b1) begin n_err++; $display("FAIL m3_idle_sclk got %b exp 1", sclk1); end
    for (int k = 0; k < 4; k++) begin
      din1 = (k == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      pat1 = (k == 0) ? 8'h3C : 8'($urandom_range(0, 255));
      pidx1 = 0; edges1 = 0; dones1 = 0; cap1.delete();
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      cnt = 0;
      while (busy1 === 1'b1 && cnt < 500) begin cnt++; tick(); end
      n_vec++; if (cnt != 17) begin n_err++; $display("FAIL m3_%0d_busy_len got %0d exp 17", k, cnt); end
      n_vec++; if (dout1 !== pat1) begin n_err++; $display("FAIL m3_%0d_dout got %h exp %h", k, dout1, pat1); end
      n_vec++; if (sclk1 !== 1'b1) begin n_err++; $display("FAIL m3_%0d_end_sclk got %b exp 1", k, sclk1); end
      tick();
      n_vec++; if (dones1 != 1) begin n_err++; $display("FAIL m3_%0d_done_count got %0d exp 1", k, dones1); end
      n_vec++; if (edges1 != 16) begin n_err++; $display("FAIL m3_%0d_edges got %0d exp 16", k, edges1); end
      n_vec++; if (cap1.size() != 8) begin n_err++; $display("FAIL m3_%0d_mosi_count got %0d exp 8", k, cap1.size()); end
      for (int i = 0; i < 8 && i < cap1.size(); i++) begin
        n_vec++;
        if (cap1[i] !== ((din1 >> (7 - i)) & 8'h1) != 0)
          begin n_err++; $display("FAIL m3_%0d_mosi_bit%0d got %b exp %b", k, i, cap1[i], din1[7-i]); end
      end
    end
  endtask

  task automatic test_ignored_start();
    int cnt;
    logic [7:0] d;
    d = 8'($urandom_range(0, 255));
    dones0 = 0;
    start_xfer0(d);
    cnt = 0;
    while (busy0 === 1'b1 && cnt < 500) begin
      cnt++;
      start0 = (cnt == 10 || cnt == 40);
      din0 = ~d;
      tick();
    end
    start0 = 1'b0;
    n_vec++; if (cnt != 68) begin n_err++; $display("FAIL ign_busy_len got %0d exp 68", cnt); end
    n_vec++; if (dout0 !== d) begin n_err++; $display("FAIL ign_dout got %h exp %h", dout0, d); end
    tick();
    tick();
    n_vec++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL ign_queued got busy %b exp 0", busy0); end
    n_vec++; if (dones0 != 1) begin n_err++; $display("FAIL ign_done_count got %0d exp 1", dones0); end
  endtask

  task automatic test_back_to_back();
    int cnt;
    start_xfer0(8'hFF);
    wait_busy0(cnt);
    n_vec++; if (dout0 !== 8'hFF) begin n_err++; $display("FAIL b2b_first_dout got %h exp ff", dout0); end
    n_vec++; if (done0 !== 1'b1) begin n_err++; $display("FAIL b2b_first_done got %b exp 1", done0); end
    start_xfer0(8'h5A);
    n_vec++; if (busy0 !== 1'b1) begin n_err++; $display("FAIL b2b_gap got busy %b exp 1", busy0); end
    wait_busy0(cnt);
    n_vec++; if (cnt != 68) begin n_err++; $display("FAIL b2b_busy_len got %0d exp 68", cnt); end
    n_vec++; if (dout0 !== 8'h5A) begin n_err++; $display("FAIL b2b_second_dout got %h exp 5a", dout0); end
    tick();
  endtask

  task automatic test_abort();
    dones0 = 0;
    start_xfer0(8'hC3);
    for (int i = 1; i < 20; i++) tick();
    cs0 = 1'b1;
    tick();
    n_vec++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL abort_busy got %b exp 0", busy0); end
    n_vec++; if (sclk0 !== 1'b0) begin n_err++; $display("FAIL abort_sclk got %b exp 0", sclk0); end
    n_vec++; if (mosi0 !== 1'b1) begin n_err++; $display("FAIL abort_mosi got %b exp 1", mosi0); end
    n_vec++; if (dout0 !== 8'h5A) begin n_err++; $display("FAIL abort_dout got %h exp 5a", dout0); end
    start_xfer0(8'h81);
    n_vec++; if (busy0 !== 1'b1) begin n_err++; $display("FAIL cs_start_accept got %b exp 1", busy0); end
    tick();
    n_vec++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL cs_start_abort got %b exp 0", busy0); end
    cs0 = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    n_vec++; if (dones0 != 0) begin n_err++; $display("FAIL abort_done_count got %0d exp 0", dones0); end
    n_vec++; if (dout0 !== 8'h5A) begin n_err++; $display("FAIL abort_dout_hold got %h exp 5a", dout0); end
  endtask

  task automatic test_reset_mid();
    int cnt;
    logic [7:0] d;
    start_xfer0(8'h96);
    for (int i = 1; i < 30; i++) tick();
    HRESETn = 1'b0;
    #1;
    n_vec++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL rmid_busy got %b exp 0", busy0); end
    n_vec++; if (done0 !== 1'b0) begin n_err++; $display("FAIL rmid_done got %b exp 0", done0); end
    n_vec++; if (dout0 !== 8'h00) begin n_err++; $display("FAIL rmid_dout got %h exp 00", dout0); end
    n_vec++; if (sclk0 !== 1'b0) begin n_err++; $display("FAIL rmid_sclk got %b exp 0", sclk0); end
    n_vec++; if (mosi0 !== 1'b1) begin n_err++; $display("FAIL rmid_mosi got %b exp 1", mosi0); end
    tick();
    HRESETn = 1'b1;
    tick();
    d = 8'($urandom_range(0, 255));
    edges0 = 0; dones0 = 0;
    start_xfer0(d);
    wait_busy0(cnt);
    n_vec++; if (cnt != 68) begin n_err++; $display("FAIL rmid_fresh_len got %0d exp 68", cnt); end
    n_vec++; if (dout0 !== d) begin n_err++; $display("FAIL rmid_fresh_dout got %h exp %h", dout0, d); end
    tick();
    n_vec++; if (edges0 != 16) begin n_err++; $display("FAIL rmid_fresh_edges got %0d exp 16", edges0); end
    n_vec++; if (dones0 != 1) begin n_err++; $display("FAIL rmid_fresh_done got %0d exp 1", dones0); end
  endtask

  initial begin
    test_reset();
    test_loopback_a5();
    test_random_data();
    test_mode3();
    test_ignored_start();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
